// File: rtl/neuron_accumulator.sv
// neuron_accumulator: (x,w) MAC, rounds (NEURON_ACC_ROUND_EN) and saturates to Q_INT.Q_FRAC.
// Result valid one edge after the last beat; in_ready stays low through FLUSH/HOLD until out_ready.
package neuron_pkg;
  localparam int Q_INT         = 8;
  localparam int Q_FRAC        = 8;
  localparam int ACT_MASK_SIZE = 2;
endpackage

module neuron_accumulator #(
  parameter int Q_INT         = neuron_pkg::Q_INT,
  parameter int Q_FRAC        = neuron_pkg::Q_FRAC,
  parameter int ACC_GUARD     = 8,
  parameter int ACT_MASK_SIZE = neuron_pkg::ACT_MASK_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic signed [Q_INT+Q_FRAC-1:0]  x_in,
  input  logic signed [Q_INT+Q_FRAC-1:0]  w_in,
  input  logic        [ACT_MASK_SIZE-1:0] mask_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic        [Q_INT+Q_FRAC-1:0]  out_data,
  output logic        [ACT_MASK_SIZE-1:0] mask_out,
  output logic                            out_sat
);

  localparam int Q_SIZE = Q_INT + Q_FRAC;
  localparam int P_W    = 2 * Q_SIZE;
  localparam int ACC_W  = P_W + ACC_GUARD;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-Q_SIZE+2){1'b0}}, {(Q_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-Q_SIZE+2){1'b1}}, {(Q_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  state_t                    state;
  logic signed [P_W-1:0]     prod;
  logic                      prod_vld;
  logic                      prod_last;
  logic signed [ACC_W-1:0]   acc;
  logic                      ovf;
  logic [ACT_MASK_SIZE-1:0]  mask_q;

  logic                      accept;
  logic signed [P_W-1:0]     x_ext;
  logic signed [P_W-1:0]     w_ext;
  logic signed [P_W-1:0]     prod_d;
  logic signed [ACC_W-1:0]   prod_sx;
  logic signed [ACC_W-1:0]   sum;
  logic                      add_ovf;
  logic signed [ACC_W:0]     s_ext;
  logic signed [ACC_W:0]     s_rnd;
  logic signed [ACC_W:0]     s_shr;
  logic [Q_SIZE-1:0]         clip_val;
  logic                      clip_hit;

  assign accept = in_valid && in_ready;

  assign x_ext  = {{Q_SIZE{x_in[Q_SIZE-1]}}, x_in};
  assign w_ext  = {{Q_SIZE{w_in[Q_SIZE-1]}}, w_in};
  assign prod_d = x_ext * w_ext;

  assign prod_sx = {{ACC_GUARD{prod[P_W-1]}}, prod};
  assign sum     = acc + prod_sx;
  assign add_ovf = (acc[ACC_W-1] == prod_sx[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // One extra MSB so the rounding increment can never wrap the sum.
  assign s_ext = {sum[ACC_W-1], sum};
`ifdef NEURON_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W+1-Q_FRAC){1'b0}}, 1'b1, {(Q_FRAC-1){1'b0}}};
  assign s_rnd = s_ext + HALF;
`else
  assign s_rnd = s_ext;
`endif
  assign s_shr = s_rnd >>> Q_FRAC;

  always_comb begin
    clip_val = s_shr[Q_SIZE-1:0];
    clip_hit = 1'b0;
    if (s_shr > SAT_MAX) begin
      clip_val = {1'b0, {(Q_SIZE-1){1'b1}}};
      clip_hit = 1'b1;
    end else if (s_shr < SAT_MIN) begin
      clip_val = {1'b1, {(Q_SIZE-1){1'b0}}};
      clip_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      prod      <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mask_out  <= '0;
      out_sat   <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod      <= prod_d;
        prod_last <= in_last;
        if (in_last) mask_q <= mask_in;
      end

      // The final product is folded in while the result is formed; acc restarts at zero.
      if (prod_vld) begin
        if (prod_last) begin
          acc       <= '0;
          ovf       <= 1'b0;
          out_data  <= clip_val;
          out_sat   <= clip_hit | ovf | add_ovf;
          mask_out  <= mask_q;
          out_valid <= 1'b1;
        end else begin
          acc <= sum;
          ovf <= ovf | add_ovf;
        end
      end

      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: state <= HOLD;
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator (Q8.8) with an arithmetic reference model and per-cycle output compare.
module tb_neuron_accumulator;

`ifdef NEURON_ACC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
  logic [15:0] x_in, w_in, out_data;
  logic [1:0]  mask_in, mask_out;

  always #5 clk = ~clk;

  neuron_accumulator #(.Q_INT(8), .Q_FRAC(8), .ACC_GUARD(8), .ACT_MASK_SIZE(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .x_in(x_in), .w_in(w_in), .mask_in(mask_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mask_out(mask_out), .out_sat(out_sat)
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic        s;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cur_x[$];
  logic [15:0] cur_w[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Exact integer sum of products, then round/floor, clip and flag.
  function automatic exp_t model_now(input logic [1:0] m);
    exp_t   e;
    longint sum = 0;
    longint q;
    longint lim = (longint'(1) <<< 39) - 1;
    bit     ovf = 1'b0;
    bit     clip = 1'b0;
    foreach (cur_x[i]) begin
      sum += longint'($signed(cur_x[i])) * longint'($signed(cur_w[i]));
      if (sum > lim || sum < -lim - 1) ovf = 1'b1;
    end
    if (RND) sum += 128;
    q = sum >>> 8;
    if (q > 32767) begin
      e.d = 16'h7FFF; clip = 1'b1;
    end else if (q < -32768) begin
      e.d = 16'h8000; clip = 1'b1;
    end else begin
      e.d = q[15:0];
    end
    e.m = m;
    e.s = clip | ovf;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("cmp_unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("cmp_data", {16'd0, out_data}, {16'd0, exp_q[0].d});
        chk("cmp_mask", {30'd0, mask_out}, {30'd0, exp_q[0].m});
        chk("cmp_sat", {31'd0, out_sat}, {31'd0, exp_q[0].s});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic last,
                      input logic [1:0] m);
    int n = 0;
    in_valid = 1'b1; x_in = x; w_in = w; in_last = last; mask_in = m;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cur_x.push_back(x);
    cur_w.push_back(w);
    if (last) begin
      exp_q.push_back(model_now(m));
      cur_x.delete();
      cur_w.delete();
    end
    in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [15:0] d, output logic [1:0] m, output logic s);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    d = out_data; m = mask_out; s = out_sat;
  endtask

  logic [15:0] d0;
  logic [1:0]  m0;
  logic        s0;
  exp_t        pin;
  int          lo;
  int          hs_cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_last = 0; x_in = 0; w_in = 0; mask_in = 0; out_ready = 1;
    rst = 0;
    #1 rst = 1;
    #5;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_mask_out", {30'd0, mask_out}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beat 1.0 x 2.0, latency exactly one edge.
    beat(16'h0100, 16'h0200, 1'b1, 2'b11);
    chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_after_1", {31'd0, out_valid}, 32'd1);
    get_result(d0, m0, s0);
    chk("t1_data", {16'd0, d0}, 32'h0200);
    chk("t1_mask", {30'd0, m0}, 32'd3);
    chk("t1_sat", {31'd0, s0}, 32'd0);
    @(posedge clk); #1;

    // Pin the model on the three-beat case, then run it.
    cur_x.push_back(16'h0100); cur_w.push_back(16'h0180);
    cur_x.push_back(16'hFF80); cur_w.push_back(16'h0200);
    cur_x.push_back(16'h0040); cur_w.push_back(16'h0400);
    pin = model_now(2'b01);
    chk("model_pin_3beat", {16'd0, pin.d}, 32'h0180);
    cur_x.delete(); cur_w.delete();

    beat(16'h0100, 16'h0180, 1'b0, 2'b00);
    beat(16'hFF80, 16'h0200, 1'b0, 2'b00);
    beat(16'h0040, 16'h0400, 1'b1, 2'b01);
    lo = 0;
    d0 = 16'hDEAD;
    while (!in_ready && lo < 20) begin
      if (out_valid) d0 = out_data;
      lo++;
      @(posedge clk); #1;
    end
    chk("t2_in_ready_low_cycles", lo, 32'd2);
    chk("t2_data", {16'd0, d0}, 32'h0180);

    // Positive and negative saturation.
    for (int i = 0; i < 99; i++) beat(16'h7F00, 16'h7F00, 1'b0, 2'b10);
    beat(16'h7F00, 16'h7F00, 1'b1, 2'b10);
    get_result(d0, m0, s0);
    chk("t3_pos_data", {16'd0, d0}, 32'h7FFF);
    chk("t3_pos_sat", {31'd0, s0}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 99; i++) beat(16'h7F00, 16'h8100, 1'b0, 2'b01);
    beat(16'h7F00, 16'h8100, 1'b1, 2'b01);
    get_result(d0, m0, s0);
    chk("t3_neg_data", {16'd0, d0}, 32'h8000);
    chk("t3_neg_sat", {31'd0, s0}, 32'd1);
    @(posedge clk); #1;

    // Half-LSB product: truncates to 0, rounds to 1.
    beat(16'h0001, 16'h0080, 1'b1, 2'b00);
    get_result(d0, m0, s0);
    chk("t4_round_data", {16'd0, d0}, RND ? 32'h0001 : 32'h0000);
    @(posedge clk); #1;

    // Backpressure for 5 cycles, then next beat right after the handshake.
    beat(16'h0100, 16'h0300, 1'b1, 2'b01);
    out_ready = 1'b0;
    get_result(d0, m0, s0);
    chk("t5_data", {16'd0, d0}, 32'h0300);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_data", {16'd0, out_data}, 32'h0300);
      chk("t5_hold_mask", {30'd0, mask_out}, 32'd1);
      chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; x_in = 16'h0100; w_in = 16'h0100; in_last = 1'b1; mask_in = 2'b10;
    @(posedge clk); #1;
    hs_cyc = cyc;
    chk("t5_valid_dropped", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready_back", {31'd0, in_ready}, 32'd1);
    beat(16'h0100, 16'h0100, 1'b1, 2'b10);
    chk("t5_accept_next_cycle", cyc - hs_cyc, 32'd1);
    get_result(d0, m0, s0);
    chk("t5_next_data", {16'd0, d0}, 32'h0100);
    @(posedge clk); #1;

    // Reset mid-neuron discards the partial sum.
    beat(16'h0200, 16'h0200, 1'b0, 2'b11);
    beat(16'h0300, 16'h0100, 1'b0, 2'b11);
    rst = 1'b1;
    cur_x.delete(); cur_w.delete(); exp_q.delete();
    #2;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    beat(16'h0100, 16'h0100, 1'b1, 2'b01);
    get_result(d0, m0, s0);
    chk("t6_data", {16'd0, d0}, 32'h0100);
    chk("t6_sat", {31'd0, s0}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("all_results_seen", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
